// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared widths, the queued write entry and requester identifiers for the
// register file writeback arbiter.
package regfile_wb_arbiter_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int REG_DATA_W = 32;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] addr;
    logic [REG_DATA_W-1:0] data;
  } wb_entry_t;

  // Recorded in the round-robin pointer as "last granted requester".
  typedef enum logic {
    REQ_ALU = 1'b0,
    REQ_MEM = 1'b1
  } req_id_t;

endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// Writeback bus: ALU and load handshakes, register file write port and the
// decode-stage forwarding lookup. The pipeline side is the master.
interface regfile_wb_arbiter_if #(
  parameter int DEPTH = 4
);
  import regfile_wb_arbiter_pkg::*;

  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic                  alu_valid;
  logic                  alu_ready;
  logic [REG_ADDR_W-1:0] alu_addr;
  logic [REG_DATA_W-1:0] alu_data;

  logic                  mem_valid;
  logic                  mem_ready;
  logic [REG_ADDR_W-1:0] mem_addr;
  logic [REG_DATA_W-1:0] mem_data;

  logic                  rf_hold;
  logic                  rf_rw;
  logic [REG_ADDR_W-1:0] rf_addr;
  logic [REG_DATA_W-1:0] rf_data;

  logic [REG_ADDR_W-1:0] rs_addr;
  logic [REG_ADDR_W-1:0] rt_addr;
  logic                  rs_hit;
  logic                  rt_hit;
  logic [REG_DATA_W-1:0] rs_fwd;
  logic [REG_DATA_W-1:0] rt_fwd;

  logic [CNT_W-1:0]      q_count;

  modport master (
    output alu_valid, alu_addr, alu_data,
    output mem_valid, mem_addr, mem_data,
    output rf_hold, rs_addr, rt_addr,
    input  alu_ready, mem_ready,
    input  rf_rw, rf_addr, rf_data,
    input  rs_hit, rt_hit, rs_fwd, rt_fwd, q_count
  );

  modport slave (
    input  alu_valid, alu_addr, alu_data,
    input  mem_valid, mem_addr, mem_data,
    input  rf_hold, rs_addr, rt_addr,
    output alu_ready, mem_ready,
    output rf_rw, rf_addr, rf_data,
    output rs_hit, rt_hit, rs_fwd, rt_fwd, q_count
  );

endinterface

// File: rtl/regfile_wb_arbiter_wb_fifo.sv
// Write queue: circular storage, occupancy count, a registered head entry
// and an associative lookup returning the youngest matching entry.
module wb_fifo
  import regfile_wb_arbiter_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push,
  input  wb_entry_t             push_entry,
  input  logic                  pop,
  output logic [$clog2(DEPTH):0] count,
  output wb_entry_t             head,
  input  logic [REG_ADDR_W-1:0] rs_addr,
  input  logic [REG_ADDR_W-1:0] rt_addr,
  output logic                  rs_hit,
  output logic                  rt_hit,
  output logic [REG_DATA_W-1:0] rs_fwd,
  output logic [REG_DATA_W-1:0] rt_fwd
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  wb_entry_t        slots [DEPTH];
  logic [PTR_W-1:0] rd_ptr, wr_ptr, rd_next, idx;
  logic [CNT_W-1:0] cnt_q, cnt_next, remain;
  wb_entry_t        head_q, head_next;

  // Next occupancy and next head; an empty-after-pop queue takes the
  // incoming write straight into the head register, otherwise it holds.
  always_comb begin
    rd_next   = pop ? rd_ptr + PTR_W'(1) : rd_ptr;
    remain    = cnt_q - CNT_W'(pop);
    cnt_next  = remain + CNT_W'(push);
    head_next = head_q;
    if (push && remain == '0) begin
      head_next = push_entry;
    end else if (remain != '0) begin
      head_next = slots[rd_next];
    end
  end

  // Pointers, count and the registered head that drives the write port.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt_q  <= '0;
      head_q <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      rd_ptr <= rd_next;
      cnt_q  <= cnt_next;
      head_q <= head_next;
    end
  end

  // Storage; slots outside the occupied window are never looked at.
  always_ff @(posedge clk) begin
    if (push) slots[wr_ptr] <= push_entry;
  end

  // Walk oldest to youngest so the youngest match wins; register 0 never hits.
  always_comb begin
    rs_hit = 1'b0;
    rt_hit = 1'b0;
    rs_fwd = '0;
    rt_fwd = '0;
    idx    = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = rd_ptr + PTR_W'(k);
      if (CNT_W'(k) < cnt_q) begin
        if (rs_addr != '0 && slots[idx].addr == rs_addr) begin
          rs_hit = 1'b1;
          rs_fwd = slots[idx].data;
        end
        if (rt_addr != '0 && slots[idx].addr == rt_addr) begin
          rt_hit = 1'b1;
          rt_fwd = slots[idx].data;
        end
      end
    end
  end

  assign count = cnt_q;
  assign head  = head_q;

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter merging ALU and load writebacks into one register
// file write port through a small write queue with forwarding lookup.
module regfile_wb_arbiter
  import regfile_wb_arbiter_pkg::*;
#(
  parameter int DEPTH     = 4,
  parameter bit DROP_ZERO = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  regfile_wb_arbiter_if.slave  bus
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic [CNT_W-1:0]      count;
  logic                  full;
  logic                  alu_ready, mem_ready;
  logic                  alu_fire, mem_fire;
  logic                  push, pop;
  wb_entry_t             push_entry, head;
  req_id_t               last_grant;
  logic                  rs_hit, rt_hit;
  logic [REG_DATA_W-1:0] rs_fwd, rt_fwd;

  // Handshake: with both valid, the requester not granted last wins; a lone
  // valid always wins. Ready never depends on the requester's own valid.
  always_comb begin
    full      = (count == CNT_W'(DEPTH));
    alu_ready = rst_n && !full && (!bus.mem_valid || last_grant == REQ_MEM);
    mem_ready = rst_n && !full && (!bus.alu_valid || last_grant == REQ_ALU);
    alu_fire  = bus.alu_valid && alu_ready;
    mem_fire  = bus.mem_valid && mem_ready;
    push_entry.addr = mem_fire ? bus.mem_addr : bus.alu_addr;
    push_entry.data = mem_fire ? bus.mem_data : bus.alu_data;
    push = (alu_fire || mem_fire) && !(DROP_ZERO && push_entry.addr == '0);
    pop  = rst_n && (count != '0) && !bus.rf_hold;
  end

  // Round-robin pointer; discarded r0 writes leave it untouched.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last_grant <= REQ_ALU;
    end else if (push) begin
      last_grant <= mem_fire ? REQ_MEM : REQ_ALU;
    end
  end

  wb_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (push),
    .push_entry (push_entry),
    .pop        (pop),
    .count      (count),
    .head       (head),
    .rs_addr    (bus.rs_addr),
    .rt_addr    (bus.rt_addr),
    .rs_hit     (rs_hit),
    .rt_hit     (rt_hit),
    .rs_fwd     (rs_fwd),
    .rt_fwd     (rt_fwd)
  );

  assign bus.alu_ready = alu_ready;
  assign bus.mem_ready = mem_ready;
  assign bus.rf_rw     = pop;
  assign bus.rf_addr   = head.addr;
  assign bus.rf_data   = head.data;
  assign bus.q_count   = count;
  assign bus.rs_hit    = rst_n && rs_hit;
  assign bus.rt_hit    = rst_n && rt_hit;
  assign bus.rs_fwd    = rst_n ? rs_fwd : '0;
  assign bus.rt_fwd    = rst_n ? rt_fwd : '0;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter with DEPTH=4, DROP_ZERO=1.
// Inputs change just after a rising edge; outputs are sampled at the falling edge.
module tb_regfile_wb_arbiter;

  logic clk;
  logic rst_n;
  int   n_pass;
  int   n_total;

  regfile_wb_arbiter_if #(.DEPTH(4)) bus ();

  regfile_wb_arbiter #(
    .DEPTH     (4),
    .DROP_ZERO (1'b1)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.alu_valid = 1'b0;
    bus.alu_addr  = '0;
    bus.alu_data  = '0;
    bus.mem_valid = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_data  = '0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.rf_hold = 1'b0;
    bus.alu_valid = 1'b1; bus.alu_addr = 5'd5; bus.alu_data = 32'h1;
    bus.mem_valid = 1'b1; bus.mem_addr = 5'd6; bus.mem_data = 32'h2;
    bus.rs_addr = 5'd5; bus.rt_addr = 5'd6;
    step();
    @(negedge clk);
    n_total++; if (bus.alu_ready !== 1'b0) $display("FAIL reset_alu_ready got=%0h exp=0", bus.alu_ready); else n_pass++;
    n_total++; if (bus.mem_ready !== 1'b0) $display("FAIL reset_mem_ready got=%0h exp=0", bus.mem_ready); else n_pass++;
    n_total++; if (bus.q_count !== 3'd0) $display("FAIL reset_q_count got=%0d exp=0", bus.q_count); else n_pass++;
    n_total++; if (bus.rf_rw !== 1'b0) $display("FAIL reset_rf_rw got=%0h exp=0", bus.rf_rw); else n_pass++;
    n_total++; if (bus.rf_addr !== 5'd0) $display("FAIL reset_rf_addr got=%0d exp=0", bus.rf_addr); else n_pass++;
    n_total++; if (bus.rf_data !== 32'd0) $display("FAIL reset_rf_data got=%0h exp=0", bus.rf_data); else n_pass++;
    n_total++; if (bus.rs_hit !== 1'b0 || bus.rt_hit !== 1'b0) $display("FAIL reset_hits got=%0h%0h exp=00", bus.rs_hit, bus.rt_hit); else n_pass++;
    step();
    rst_n = 1'b1;
    idle();
    bus.rs_addr = '0; bus.rt_addr = '0;
  endtask

  task automatic test_single_alu();
    bus.alu_valid = 1'b1; bus.alu_addr = 5'd5; bus.alu_data = 32'h0000_00AA;
    @(negedge clk);
    n_total++; if (bus.alu_ready !== 1'b1) $display("FAIL single_alu_ready got=%0h exp=1", bus.alu_ready); else n_pass++;
    step();
    idle();
    @(negedge clk);
    n_total++; if (bus.rf_rw !== 1'b1) $display("FAIL single_rf_rw got=%0h exp=1", bus.rf_rw); else n_pass++;
    n_total++; if (bus.rf_addr !== 5'd5) $display("FAIL single_rf_addr got=%0d exp=5", bus.rf_addr); else n_pass++;
    n_total++; if (bus.rf_data !== 32'hAA) $display("FAIL single_rf_data got=%0h exp=aa", bus.rf_data); else n_pass++;
    n_total++; if (bus.q_count !== 3'd1) $display("FAIL single_q_count_busy got=%0d exp=1", bus.q_count); else n_pass++;
    step();
    @(negedge clk);
    n_total++; if (bus.q_count !== 3'd0) $display("FAIL single_q_count_done got=%0d exp=0", bus.q_count); else n_pass++;
    n_total++; if (bus.rf_rw !== 1'b0) $display("FAIL single_rf_rw_done got=%0h exp=0", bus.rf_rw); else n_pass++;
    n_total++; if (bus.rf_addr !== 5'd5 || bus.rf_data !== 32'hAA) $display("FAIL single_hold_last got=%0d/%0h exp=5/aa", bus.rf_addr, bus.rf_data); else n_pass++;
    step();
  endtask

  task automatic test_drop_zero();
    bus.alu_valid = 1'b1; bus.alu_addr = 5'd0; bus.alu_data = 32'h55;
    @(negedge clk);
    n_total++; if (bus.alu_ready !== 1'b1) $display("FAIL drop_alu_ready got=%0h exp=1", bus.alu_ready); else n_pass++;
    step();
    idle();
    bus.mem_valid = 1'b1; bus.mem_addr = 5'd0; bus.mem_data = 32'h66;
    @(negedge clk);
    n_total++; if (bus.mem_ready !== 1'b1) $display("FAIL drop_mem_ready got=%0h exp=1", bus.mem_ready); else n_pass++;
    n_total++; if (bus.q_count !== 3'd0) $display("FAIL drop_q_count_alu got=%0d exp=0", bus.q_count); else n_pass++;
    n_total++; if (bus.rf_rw !== 1'b0) $display("FAIL drop_rf_rw_alu got=%0h exp=0", bus.rf_rw); else n_pass++;
    step();
    idle();
    @(negedge clk);
    n_total++; if (bus.q_count !== 3'd0) $display("FAIL drop_q_count_mem got=%0d exp=0", bus.q_count); else n_pass++;
    n_total++; if (bus.rf_rw !== 1'b0) $display("FAIL drop_rf_rw_mem got=%0h exp=0", bus.rf_rw); else n_pass++;
    // last real grant was ALU, so a contended cycle must still go to MEM
    bus.alu_valid = 1'b1; bus.alu_addr = 5'd1; bus.alu_data = 32'h1;
    bus.mem_valid = 1'b1; bus.mem_addr = 5'd2; bus.mem_data = 32'h2;
    #1;
    n_total++; if (bus.mem_ready !== 1'b1 || bus.alu_ready !== 1'b0) $display("FAIL drop_rr_kept got=m%0h/a%0h exp=m1/a0", bus.mem_ready, bus.alu_ready); else n_pass++;
    idle();
    step();
  endtask

  task automatic test_arbitration();
    logic [4:0]  exp_addr;
    logic [31:0] exp_data;
    do_reset();
    bus.rf_hold = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.alu_valid = 1'b1; bus.alu_addr = 5'(10 + i); bus.alu_data = 32'hA0 + 32'(i);
      bus.mem_valid = 1'b1; bus.mem_addr = 5'(20 + i); bus.mem_data = 32'hB0 + 32'(i);
      @(negedge clk);
      n_total++; if (bus.mem_ready !== (i % 2 == 0) || bus.alu_ready !== (i % 2 == 1))
        $display("FAIL arb_grant_%0d got=m%0h/a%0h exp=m%0h/a%0h", i, bus.mem_ready, bus.alu_ready, (i % 2 == 0), (i % 2 == 1));
      else n_pass++;
      n_total++; if (bus.q_count !== 3'(i)) $display("FAIL arb_fill_count_%0d got=%0d exp=%0d", i, bus.q_count, i); else n_pass++;
      step();
    end
    @(negedge clk);
    n_total++; if (bus.alu_ready !== 1'b0 || bus.mem_ready !== 1'b0) $display("FAIL arb_full_ready got=m%0h/a%0h exp=m0/a0", bus.mem_ready, bus.alu_ready); else n_pass++;
    n_total++; if (bus.q_count !== 3'd4) $display("FAIL arb_full_count got=%0d exp=4", bus.q_count); else n_pass++;
    n_total++; if (bus.rf_rw !== 1'b0) $display("FAIL arb_hold_rf_rw got=%0h exp=0", bus.rf_rw); else n_pass++;
    step();
    idle();
    bus.rf_hold = 1'b0;
    for (int j = 0; j < 4; j++) begin
      exp_addr = (j % 2 == 0) ? 5'(20 + j) : 5'(10 + j);
      exp_data = (j % 2 == 0) ? 32'hB0 + 32'(j) : 32'hA0 + 32'(j);
      @(negedge clk);
      n_total++; if (bus.rf_rw !== 1'b1 || bus.rf_addr !== exp_addr || bus.rf_data !== exp_data)
        $display("FAIL arb_commit_%0d got=rw%0h/%0d/%0h exp=rw1/%0d/%0h", j, bus.rf_rw, bus.rf_addr, bus.rf_data, exp_addr, exp_data);
      else n_pass++;
      step();
    end
    @(negedge clk);
    n_total++; if (bus.q_count !== 3'd0 || bus.rf_rw !== 1'b0) $display("FAIL arb_drained got=%0d/rw%0h exp=0/rw0", bus.q_count, bus.rf_rw); else n_pass++;
    step();
  endtask

  task automatic test_forward();
    bus.rf_hold = 1'b1;
    bus.alu_valid = 1'b1; bus.alu_addr = 5'd7; bus.alu_data = 32'h11;
    step();
    idle();
    bus.mem_valid = 1'b1; bus.mem_addr = 5'd9; bus.mem_data = 32'h33;
    step();
    idle();
    bus.alu_valid = 1'b1; bus.alu_addr = 5'd7; bus.alu_data = 32'h22;
    step();
    idle();
    bus.rs_addr = 5'd7; bus.rt_addr = 5'd9;
    @(negedge clk);
    n_total++; if (bus.q_count !== 3'd3) $display("FAIL fwd_count got=%0d exp=3", bus.q_count); else n_pass++;
    n_total++; if (bus.rs_hit !== 1'b1 || bus.rs_fwd !== 32'h22) $display("FAIL fwd_rs_youngest got=%0h/%0h exp=1/22", bus.rs_hit, bus.rs_fwd); else n_pass++;
    n_total++; if (bus.rt_hit !== 1'b1 || bus.rt_fwd !== 32'h33) $display("FAIL fwd_rt_r9 got=%0h/%0h exp=1/33", bus.rt_hit, bus.rt_fwd); else n_pass++;
    bus.rt_addr = 5'd0;
    #1;
    n_total++; if (bus.rt_hit !== 1'b0 || bus.rt_fwd !== 32'h0) $display("FAIL fwd_rt_r0 got=%0h/%0h exp=0/0", bus.rt_hit, bus.rt_fwd); else n_pass++;
    step();
    bus.rf_hold = 1'b0;
    bus.rt_addr = 5'd9;
    @(negedge clk);
    n_total++; if (bus.rf_rw !== 1'b1 || bus.rf_addr !== 5'd7 || bus.rf_data !== 32'h11) $display("FAIL fwd_commit0 got=rw%0h/%0d/%0h exp=rw1/7/11", bus.rf_rw, bus.rf_addr, bus.rf_data); else n_pass++;
    step();
    @(negedge clk);
    n_total++; if (bus.rf_addr !== 5'd9 || bus.rf_data !== 32'h33 || bus.rt_hit !== 1'b1) $display("FAIL fwd_commit1 got=%0d/%0h/hit%0h exp=9/33/hit1", bus.rf_addr, bus.rf_data, bus.rt_hit); else n_pass++;
    step();
    @(negedge clk);
    n_total++; if (bus.rf_addr !== 5'd7 || bus.rf_data !== 32'h22) $display("FAIL fwd_commit2 got=%0d/%0h exp=7/22", bus.rf_addr, bus.rf_data); else n_pass++;
    n_total++; if (bus.rs_hit !== 1'b1 || bus.rs_fwd !== 32'h22) $display("FAIL fwd_popping_head got=%0h/%0h exp=1/22", bus.rs_hit, bus.rs_fwd); else n_pass++;
    n_total++; if (bus.rt_hit !== 1'b0) $display("FAIL fwd_rt_gone got=%0h exp=0", bus.rt_hit); else n_pass++;
    step();
    @(negedge clk);
    n_total++; if (bus.rs_hit !== 1'b0 || bus.rs_fwd !== 32'h0) $display("FAIL fwd_empty got=%0h/%0h exp=0/0", bus.rs_hit, bus.rs_fwd); else n_pass++;
    step();
    bus.rs_addr = '0; bus.rt_addr = '0;
  endtask

  task automatic test_back_to_back_full();
    do_reset();
    bus.rf_hold = 1'b1;
    bus.alu_valid = 1'b1; bus.alu_addr = 5'd3; bus.alu_data = 32'h300;
    bus.mem_valid = 1'b1; bus.mem_addr = 5'd4; bus.mem_data = 32'h400;
    for (int i = 0; i < 4; i++) step();
    bus.rf_hold = 1'b0;
    @(negedge clk);
    n_total++; if (bus.q_count !== 3'd4) $display("FAIL full_count got=%0d exp=4", bus.q_count); else n_pass++;
    n_total++; if (bus.alu_ready !== 1'b0 || bus.mem_ready !== 1'b0) $display("FAIL full_no_push got=m%0h/a%0h exp=m0/a0", bus.mem_ready, bus.alu_ready); else n_pass++;
    n_total++; if (bus.rf_rw !== 1'b1 || bus.rf_addr !== 5'd4) $display("FAIL full_pop got=rw%0h/%0d exp=rw1/4", bus.rf_rw, bus.rf_addr); else n_pass++;
    step();
    @(negedge clk);
    n_total++; if (bus.q_count !== 3'd3) $display("FAIL full_after_pop got=%0d exp=3", bus.q_count); else n_pass++;
    n_total++; if (bus.mem_ready !== 1'b1 || bus.alu_ready !== 1'b0) $display("FAIL full_resume_mem got=m%0h/a%0h exp=m1/a0", bus.mem_ready, bus.alu_ready); else n_pass++;
    n_total++; if (bus.rf_addr !== 5'd3) $display("FAIL full_head1 got=%0d exp=3", bus.rf_addr); else n_pass++;
    step();
    @(negedge clk);
    n_total++; if (bus.q_count !== 3'd3) $display("FAIL full_push_pop got=%0d exp=3", bus.q_count); else n_pass++;
    n_total++; if (bus.alu_ready !== 1'b1 || bus.rf_addr !== 5'd4) $display("FAIL full_head2 got=a%0h/%0d exp=a1/4", bus.alu_ready, bus.rf_addr); else n_pass++;
    step();
    @(negedge clk);
    n_total++; if (bus.q_count !== 3'd3 || bus.rf_addr !== 5'd3) $display("FAIL full_head3 got=%0d/%0d exp=3/3", bus.q_count, bus.rf_addr); else n_pass++;
    step();
    idle();
    for (int i = 0; i < 3; i++) step();
    @(negedge clk);
    n_total++; if (bus.q_count !== 3'd0) $display("FAIL full_drained got=%0d exp=0", bus.q_count); else n_pass++;
    step();
  endtask

  task automatic test_reset_mid();
    bus.rf_hold = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      bus.alu_valid = 1'b1; bus.alu_addr = 5'(i); bus.alu_data = 32'h100 + 32'(i);
      step();
    end
    rst_n = 1'b0;
    bus.rf_hold = 1'b0;
    bus.alu_addr = 5'd4; bus.alu_data = 32'h104;
    bus.rs_addr = 5'd1;
    @(negedge clk);
    n_total++; if (bus.q_count !== 3'd3) $display("FAIL rstmid_pre_count got=%0d exp=3", bus.q_count); else n_pass++;
    n_total++; if (bus.rf_rw !== 1'b0) $display("FAIL rstmid_rf_rw_in_reset got=%0h exp=0", bus.rf_rw); else n_pass++;
    n_total++; if (bus.alu_ready !== 1'b0 || bus.mem_ready !== 1'b0) $display("FAIL rstmid_ready got=m%0h/a%0h exp=m0/a0", bus.mem_ready, bus.alu_ready); else n_pass++;
    n_total++; if (bus.rs_hit !== 1'b0) $display("FAIL rstmid_rs_hit got=%0h exp=0", bus.rs_hit); else n_pass++;
    step();
    rst_n = 1'b1;
    idle();
    @(negedge clk);
    n_total++; if (bus.q_count !== 3'd0) $display("FAIL rstmid_count got=%0d exp=0", bus.q_count); else n_pass++;
    n_total++; if (bus.rf_rw !== 1'b0 || bus.rf_addr !== 5'd0 || bus.rf_data !== 32'd0) $display("FAIL rstmid_rf got=rw%0h/%0d/%0h exp=rw0/0/0", bus.rf_rw, bus.rf_addr, bus.rf_data); else n_pass++;
    for (int i = 0; i < 3; i++) begin
      step();
      @(negedge clk);
      n_total++; if (bus.rf_rw !== 1'b0) $display("FAIL rstmid_no_commit_%0d got=%0h exp=0", i, bus.rf_rw); else n_pass++;
    end
    step();
    bus.rs_addr = '0;
  endtask

  initial begin
    n_pass  = 0;
    n_total = 0;
    idle();
    test_reset();
    test_single_alu();
    test_drop_zero();
    test_arbitration();
    test_forward();
    test_back_to_back_full();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/regfile_wb_arbiter.md
REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

Interface
REQ-001 Parameter DEPTH, default 4, write-queue entries (power of two, 2..8).
REQ-002 Parameter DROP_ZERO, default 1, 1 = writes to register 0 are discarded at acceptance.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 alu_valid / alu_ready  input / output  1 / 1  ALU writeback handshake.
REQ-006 alu_addr / alu_data  input  5 / 32  ALU destination register and value.
REQ-007 mem_valid / mem_ready  input / output  1 / 1  load writeback handshake.
REQ-008 mem_addr / mem_data  input  5 / 32  load destination register and value.
REQ-009 rf_hold  input  1  1 = register file write port unavailable this cycle.
REQ-010 rf_rw / rf_addr / rf_data  output  1 / 5 / 32  register file write enable, rd, value.
REQ-011 rs_addr / rt_addr  input  5 / 5  decode-stage source registers.
REQ-012 rs_hit / rt_hit  output  1 / 1  source matches a queued, uncommitted write.
REQ-013 rs_fwd / rt_fwd  output  32 / 32  value of the youngest matching queued write; 0 when no hit.
REQ-014 q_count  output  clog2(DEPTH)+1  current queue occupancy.

Function
REQ-015 A transfer occurs on a requester when valid and ready are both 1 at a rising edge.
REQ-016 At most one transfer per cycle, across both requesters.
REQ-017 ready is 0 on both requesters when q_count == DEPTH; a same-cycle pop does not free a slot for a push.
REQ-018 Both valid and queue not full: grant goes to the requester not granted last; rr pointer resets to favour MEM.
REQ-019 Only one valid and queue not full: that requester is granted regardless of the rr pointer; the pointer then records it.
REQ-020 ready is combinational from the valids, the rr pointer and q_count; it does not depend on its own valid.
REQ-021 An accepted write with addr 0 and DROP_ZERO=1 completes the handshake but is not enqueued and does not update the rr pointer.
REQ-022 The queue is FIFO; head entry drives rf_addr and rf_data directly from flops.
REQ-023 rf_rw = (q_count != 0) && !rf_hold; the head pops at the rising edge when rf_rw is 1.
REQ-024 Latency: a write accepted at edge N with an empty queue and rf_hold low appears on rf_* in cycle N+1 and is committed by the register file at the falling edge of that cycle.
REQ-025 Simultaneous push and pop: q_count unchanged, order preserved.
REQ-026 Read and write pointers wrap modulo DEPTH.
REQ-027 rf_addr and rf_data hold their last values when the queue is empty; rf_rw is 0.
REQ-028 rs_hit/rt_hit compare against all valid queue entries, including the head being popped this cycle; source addr 0 never hits.
REQ-029 Multiple matches: forward the youngest entry's data (closest to the write pointer).
REQ-030 Hit and forward outputs are combinational from queue flops and the source inputs.

Reset
REQ-031 With rst_n low at a rising edge: queue emptied, q_count=0, pointers=0, rr favours MEM, rf_rw=0, rf_addr=0, rf_data=0.
REQ-032 During reset cycles alu_ready=mem_ready=0 and rs_hit=rt_hit=0.
REQ-033 Reset mid-operation discards all queued writes without committing them; no rf_rw pulse in the first cycle after reset releases.

Structure
REQ-034 A shared package holds REG_ADDR_W=5, REG_DATA_W=32, the write-entry struct {addr, data} and requester ID constants.
REQ-035 One sub-module, wb_fifo (storage, pointers, count, CAM-style match and forward), is instantiated once.
REQ-036 Arbitration and handshake logic reside in regfile_wb_arbiter.

Verification
REQ-037 Single ALU write of r5=0x0000_00AA with an idle queue: alu_ready=1, next cycle rf_rw=1, rf_addr=5, rf_data=0xAA, q_count returns to 0.
REQ-038 Both valid for 4 cycles with rf_hold=1 and DEPTH=4: grants MEM, ALU, MEM, ALU; fifth cycle both ready=0; release hold -> 4 commits in that order.
REQ-039 Queue holds r7=0x11 then r7=0x22 with hold=1; rs_addr=7: rs_hit=1, rs_fwd=0x22; rt_addr=0: rt_hit=0, rt_fwd=0.
REQ-040 ALU write to r0 with DROP_ZERO=1: handshake completes, q_count stays 0, no rf_rw pulse.
REQ-041 Full queue with hold=0 and both valid: pop each cycle, no push in the full cycle; push resumes next cycle; q_count never exceeds 4.
REQ-042 rst_n low for 1 cycle with 3 queued writes: q_count=0, rf_rw=0 after the edge, no queued write reaches rf_* afterwards.
